// File: rtl/data_mem_param.sv
// data_mem_param: single-port data memory with byte enables, RD_LAT-cycle reads and clear-after-reset
// Ports: clk/rst (async active-high), addr/re/we/be/wrt_data request side,
// rd_data/rd_vld read return, busy while clearing, err sticky on re&we.
module data_mem_param #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                re,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wrt_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_vld,
    output logic                busy,
    output logic                err
);
    localparam int BE_W = DATA_W / 8;
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic err_q, err_d, rd_vld_q, rd_vld_d, clr, rd_acc, wr_acc;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, mem_rd;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    if (DATA_W % 8 != 0 || (RD_LAT != 1 && RD_LAT != 2)) begin : g_bad_param
        $error("data_mem_param: DATA_W must be a multiple of 8 and RD_LAT must be 1 or 2");
    end
    assign mem_rd  = mem[addr];
    assign rd_data = rd_data_q;
    assign rd_vld  = rd_vld_q;
    assign err     = err_q;
    assign busy    = clr;
    always_comb begin
        clr     = state_q == CLEAR;
        rd_acc  = !clr && re && !we;
        wr_acc  = !clr && we && !re;
        err_d   = err_q || (!clr && re && we);
        cnt_d   = clr ? cnt_q + 1'b1 : cnt_q;
        state_d = (clr && &cnt_q) ? IDLE : state_q;
    end
    if (RD_LAT == 1) begin : g_lat1
        always_comb begin
            rd_vld_d  = rd_acc;
            rd_data_d = rd_acc ? mem_rd : rd_data_q;
        end
    end else begin : g_lat2
        // extra register stage between the array read and the output
        logic s_vld_q;
        logic [DATA_W-1:0] s_data_q, s_data_d;
        always_comb begin
            s_data_d  = rd_acc ? mem_rd : s_data_q;
            rd_vld_d  = s_vld_q;
            rd_data_d = s_vld_q ? s_data_q : rd_data_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_vld_q  <= 1'b0;
                s_data_q <= '0;
            end else begin
                s_vld_q  <= rd_acc;
                s_data_q <= s_data_d;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end
    // array has no reset; writes are suppressed while rst is held
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr)
                mem[cnt_q] <= '0;
            else if (wr_acc)
                for (int i = 0; i < BE_W; i++)
                    if (be[i]) mem[addr][8*i +: 8] <= wrt_data[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_data_mem_param.sv
// tb_data_mem_param: scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances with shared stimulus
module tb_data_mem_param;
    typedef struct {logic [15:0] d; int due;} exp_t;
    logic clk = 0, rst = 1, re = 0, we = 0;
    logic [3:0] addr = '0;
    logic [1:0] be = '0;
    logic [15:0] wrt_data = '0;
    logic [15:0] rd_data1, rd_data2;
    logic rd_vld1, rd_vld2, busy1, busy2, err1, err2;
    logic [15:0] model [16];
    exp_t q1[$], q2[$];
    int cyc = 0, pass_cnt = 0, tot_cnt = 0;
    data_mem_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .CLR_ON_RST(1)) dut1 (
        .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .be(be), .wrt_data(wrt_data),
        .rd_data(rd_data1), .rd_vld(rd_vld1), .busy(busy1), .err(err1));
    data_mem_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .CLR_ON_RST(1)) dut2 (
        .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .be(be), .wrt_data(wrt_data),
        .rd_data(rd_data2), .rd_vld(rd_vld2), .busy(busy2), .err(err2));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (!rst) begin
        if (q1.size() != 0 && q1[0].due == cyc) begin
            tot_cnt++;
            if (rd_vld1 !== 1'b1 || rd_data1 !== q1[0].d)
                $display("FAIL lat1_read: vld=%b data=%h, required vld=1 data=%h (cyc %0d)", rd_vld1, rd_data1, q1[0].d, cyc);
            else pass_cnt++;
            void'(q1.pop_front());
        end else if (rd_vld1 !== 1'b0) begin
            tot_cnt++;
            $display("FAIL lat1_spurious_vld: vld=%b, required 0 (cyc %0d)", rd_vld1, cyc);
        end
    end
    always @(negedge clk) if (!rst) begin
        if (q2.size() != 0 && q2[0].due == cyc) begin
            tot_cnt++;
            if (rd_vld2 !== 1'b1 || rd_data2 !== q2[0].d)
                $display("FAIL lat2_read: vld=%b data=%h, required vld=1 data=%h (cyc %0d)", rd_vld2, rd_data2, q2[0].d, cyc);
            else pass_cnt++;
            void'(q2.pop_front());
        end else if (rd_vld2 !== 1'b0) begin
            tot_cnt++;
            $display("FAIL lat2_spurious_vld: vld=%b, required 0 (cyc %0d)", rd_vld2, cyc);
        end
    end
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic rd(input logic [3:0] a);
        addr = a; re = 1; we = 0;
        q1.push_back(exp_t'{model[a], cyc + 1});
        q2.push_back(exp_t'{model[a], cyc + 2});
        @(posedge clk); #1;
        re = 0;
    endtask
    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        addr = a; wrt_data = d; be = b; we = 1; re = 0;
        if (b[0]) model[a][7:0] = d[7:0];
        if (b[1]) model[a][15:8] = d[15:8];
        @(posedge clk); #1;
        we = 0; be = '0;
    endtask
    task automatic rw(input logic [3:0] a, input logic [15:0] d);
        addr = a; wrt_data = d; be = 2'b11; we = 1; re = 1;
        @(posedge clk); #1;
        we = 0; re = 0; be = '0;
    endtask
    // releases rst and counts cycles each instance spends busy
    task automatic release_count(output int n1, output int n2);
        n1 = 0; n2 = 0;
        rst = 0;
        for (int k = 0; k < 100 && (busy1 || busy2); k++) begin
            if (busy1) n1++;
            if (busy2) n2++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask
    task automatic test_reset;
        int n1, n2;
        idle(2);
        tot_cnt++;
        if ({rd_data1, rd_data2} !== 32'h0 || {rd_vld1, rd_vld2, err1, err2} !== 4'b0)
            $display("FAIL reset_outputs: d1=%h d2=%h vld=%b%b err=%b%b, required all 0", rd_data1, rd_data2, rd_vld1, rd_vld2, err1, err2);
        else pass_cnt++;
        tot_cnt++;
        if ({busy1, busy2} !== 2'b11) $display("FAIL reset_busy: busy=%b%b, required 11", busy1, busy2);
        else pass_cnt++;
        release_count(n1, n2);
        tot_cnt++;
        if (n1 != 16 || n2 != 16) $display("FAIL clear_len: busy cycles %0d/%0d, required 16", n1, n2);
        else pass_cnt++;
    endtask
    task automatic test_clear_reads;
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle(3);
    endtask
    task automatic test_write_read;
        wr(4'h5, 16'hBEEF, 2'b11);
        rd(4'h5);
        idle(3);
    endtask
    task automatic test_byte_en;
        wr(4'h7, 16'h1234, 2'b11);
        wr(4'h7, 16'hABCD, 2'b01);
        rd(4'h7);
        wr(4'h7, 16'hABCD, 2'b10);
        rd(4'h7);
        wr(4'h7, 16'h0000, 2'b00);
        rd(4'h7);
        idle(3);
        tot_cnt++;
        if ({err1, err2} !== 2'b00) $display("FAIL be0_no_err: err=%b%b, required 00", err1, err2);
        else pass_cnt++;
    endtask
    task automatic test_err;
        wr(4'h3, 16'h5555, 2'b11);
        rw(4'h3, 16'h0000);
        tot_cnt++;
        if ({err1, err2} !== 2'b11) $display("FAIL err_set: err=%b%b, required 11", err1, err2);
        else pass_cnt++;
        rd(4'h3);
        idle(5);
        tot_cnt++;
        if ({err1, err2} !== 2'b11) $display("FAIL err_sticky: err=%b%b, required 11", err1, err2);
        else pass_cnt++;
    endtask
    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) wr(4'(i), 16'(i + 1), 2'b11);
        for (int i = 0; i < 4; i++) rd(4'(i));
        idle(4);
    endtask
    task automatic test_reset_mid;
        int n1, n2;
        rst = 1; idle(1);
        rst = 0;
        idle(9);
        rst = 1; idle(1);
        tot_cnt++;
        if ({err1, err2, busy1, busy2} !== 4'b0011)
            $display("FAIL mid_clear_rst: err=%b%b busy=%b%b, required err 00 busy 11", err1, err2, busy1, busy2);
        else pass_cnt++;
        release_count(n1, n2);
        tot_cnt++;
        if (n1 != 16 || n2 != 16) $display("FAIL clear_restart_len: busy cycles %0d/%0d, required 16", n1, n2);
        else pass_cnt++;
        wr(4'h2, 16'h7777, 2'b11);
        addr = 4'h2; re = 1;
        @(posedge clk); #1;
        re = 0; rst = 1;
        #1;
        tot_cnt++;
        if ({rd_vld1, rd_vld2} !== 2'b00 || {rd_data1, rd_data2} !== 32'h0)
            $display("FAIL inflight_rst: vld=%b%b d1=%h d2=%h, required 0", rd_vld1, rd_vld2, rd_data1, rd_data2);
        else pass_cnt++;
        idle(2);
        release_count(n1, n2);
        tot_cnt++;
        if (n1 != 16 || n2 != 16) $display("FAIL clear_after_inflight: busy cycles %0d/%0d, required 16", n1, n2);
        else pass_cnt++;
        rd(4'h2);
        idle(3);
    endtask
    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        test_reset;
        test_clear_reads;
        test_write_read;
        test_byte_en;
        test_err;
        test_back_to_back;
        test_reset_mid;
        idle(3);
        tot_cnt++;
        if (q1.size() != 0 || q2.size() != 0) $display("FAIL drain: pending %0d/%0d, required 0", q1.size(), q2.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
